snes_poller: RTL and testbench
==============================

# snes_poller

Console-side SNES controller reader: the other end of the link that `snes_encoder` drives. It periodically issues the latch pulse and 16 serial clock pulses on the SNES port, samples the serial data line, and presents a debounced-by-frame, active-high 16-bit button word with a one-cycle valid strobe. It runs on the 1 MHz divided clock and lets the team read a real controller, or loop back its own encoder output, for bring-up and self-test.

## Interface

Parameters:
- `HALF_CYCLES`, default 6: clock cycles per SNES clock half-period (6 µs at 1 MHz); legal values ≥ 3.
- `LATCH_CYCLES`, default 12: clock cycles the latch is held high (12 µs).
- `POLL_CYCLES`, default 16667: poll period in clock cycles (about 60 Hz); must exceed `LATCH_CYCLES + 32*HALF_CYCLES + 2`.

Ports:
- `clock` in 1: system clock (1 MHz `clock_1MHz`).
- `reset` in 1: asynchronous, active-high reset.
- `enable` in 1: allows new frames to start.
- `snes_data` in 1: serial data from the controller; active-low buttons; idles high when no controller is attached.
- `snes_latch` out 1: latch to the controller, active high.
- `snes_clk` out 1: serial clock to the controller; idles high.
- `buttons` out 16: last completed frame, active high; bit i is serial bit i (0 = B, 1 = Y, 2 = Select, 3 = Start, 4 = Up, 5 = Down, 6 = Left, 7 = Right, 8 = A, 9 = X, 10 = L, 11 = R, 12–15 = unused).
- `valid` out 1: one-cycle pulse when `buttons` updates.
- `busy` out 1: high while a frame is in progress.

## Operation

- `snes_data` passes through a 2-flop synchronizer whose flops reset to 1. All sampling uses the synchronized value.
- Poll counter: free-running, counts 0..`POLL_CYCLES`-1 and wraps. It runs whether or not `enable` is high. Width is clog2(`POLL_CYCLES`).
- The state machine has four states.
  - IDLE: `snes_latch`=0, `snes_clk`=1, `busy`=0. When the poll counter is 0 and `enable`=1, go to LATCH.
  - LATCH: `snes_latch`=1, `snes_clk`=1 for `LATCH_CYCLES` cycles. Then clear the bit index and go to SHIFT.
  - SHIFT: for each bit i = 0..15:
    - Low phase: `snes_clk`=0 for `HALF_CYCLES` cycles. On the last low cycle, shift in the data bit: shreg <= {sync_data, shreg[15:1]}.
    - High phase: `snes_clk`=1 for `HALF_CYCLES` cycles.
    - After the high phase of bit 15, go to DONE.
  - DONE, one cycle: `buttons` <= ~shreg, `valid`=1, then go to IDLE.
- `busy` is 1 in LATCH, SHIFT and DONE.
- Once started, a frame always completes. Deasserting `enable` mid-frame has no effect on that frame.
- No controller attached means the line reads all 1s, so the frame produces `buttons`=16'h0000. This is still reported with `valid`.
- The controller shifts its output on the rising edge of `snes_clk`. Bit 0 is present from latch fall onward, so sampling at the end of each low phase gives a stable bit through synchronizer latency.

## Timing

- Reset values: `snes_latch`=0, `snes_clk`=1, `buttons`=0, `valid`=0, `busy`=0, state IDLE, poll counter 0, shreg 0.
- Reset asserted mid-frame aborts the frame immediately. Outputs return to their reset values asynchronously and `buttons` is not updated.
- Frame timing, with cycle 0 defined as the first cycle `snes_latch`=1 (the cycle after IDLE sees counter=0 with `enable`=1):
  - Latch high: cycles 0..L-1.
  - Bit i low phase: cycles L+2iH .. L+2iH+H-1. The sample is taken at L+2iH+H-1.
  - Bit i high phase: the next H cycles.
  - `valid`=1 and `buttons` updated at cycle L+32H (204 with defaults).
  - `busy` is high on cycles 0..L+32H.
- The first frame after reset release starts from poll counter 0. Frames then start every `POLL_CYCLES` cycles.
- The sampled value reflects `snes_data` 2 cycles before the sample edge.

## Test plan

- Reset release with `enable`=1 and `snes_data` held at 1:
  - `snes_latch` high for exactly 12 cycles.
  - Then exactly 16 low pulses on `snes_clk`, each 6 cycles low and 6 cycles high.
  - `valid` pulses once at cycle 204 with `buttons`=16'h0000.
- Controller model, driven by `snes_latch`/`snes_clk` and shifting on the `snes_clk` rising edge, presenting pressed A and Start (raw 16'hFEF7, active low) -> `buttons`=16'h0108.
- Controller model presenting all twelve buttons pressed -> `buttons`=16'h0FFF. Frames repeat every 16667 cycles with identical values.
- `enable` dropped 50 cycles into a frame -> that frame completes with `valid`. No further `snes_latch` activity until `enable` is high when the poll counter reaches 0.
- `reset` asserted at cycle 100 of a frame:
  - Asynchronously, `snes_clk`=1, `snes_latch`=0, `busy`=0 and `buttons`=0.
  - No `valid` pulse for the aborted frame.
  - After release, a full new frame is produced.
- Loopback with `snes_encoder` loaded with 8'hA5 -> the low byte of `buttons` equals the encoder's active-high mapping of 8'hA5. Check this over 3 consecutive frames.

Source files
------------

// File: rtl/snes_poller.sv
// Console-side SNES controller reader: issues latch and 16 serial clocks once per
// poll period, samples the data line and publishes an active-high button word.
module snes_poller #(
  parameter int HALF_CYCLES  = 6,
  parameter int LATCH_CYCLES = 12,
  parameter int POLL_CYCLES  = 16667
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        snes_data,
  output logic        snes_latch,
  output logic        snes_clk,
  output logic [15:0] buttons,
  output logic        valid,
  output logic        busy
);

  localparam int PW   = $clog2(POLL_CYCLES);
  localparam int TMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [PW-1:0] poll;
  logic [TW-1:0] tcnt;
  logic [3:0]    bidx;
  logic          phase;
  logic [15:0]   shreg;

  // Reset to 1 so an unplugged port looks like "no buttons pressed".
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], snes_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                               poll <= '0;
    else if (poll == PW'(POLL_CYCLES - 1))   poll <= '0;
    else                                     poll <= poll + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      snes_latch <= 1'b0;
      snes_clk   <= 1'b1;
      buttons    <= '0;
      valid      <= 1'b0;
      busy       <= 1'b0;
      tcnt       <= '0;
      bidx       <= '0;
      phase      <= 1'b0;
      shreg      <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (poll == '0 && enable) begin
            state      <= LATCH;
            snes_latch <= 1'b1;
            busy       <= 1'b1;
            tcnt       <= '0;
          end
        end
        LATCH: begin
          if (tcnt == TW'(LATCH_CYCLES - 1)) begin
            state      <= SHIFT;
            snes_latch <= 1'b0;
            snes_clk   <= 1'b0;
            tcnt       <= '0;
            bidx       <= '0;
            phase      <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        SHIFT: begin
          if (tcnt == TW'(HALF_CYCLES - 1)) begin
            tcnt <= '0;
            if (!phase) begin
              // Sample at the end of the low phase; bit 0 lands in shreg[0] after 16 shifts.
              shreg    <= {sync[1], shreg[15:1]};
              snes_clk <= 1'b1;
              phase    <= 1'b1;
            end else if (bidx == 4'd15) begin
              state   <= DONE;
              valid   <= 1'b1;
              buttons <= ~shreg;
            end else begin
              bidx     <= bidx + 4'd1;
              snes_clk <= 1'b0;
              phase    <= 1'b0;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snes_poller.sv
// Bench for snes_poller: behavioural controller on the SNES port, per-cycle frame
// timing derived from the frame arithmetic, randomized button words.
module tb_snes_poller;

  localparam int H = 6;
  localparam int L = 12;
  localparam int P = 300;
  localparam int FEND = L + 32*H;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        snes_data;
  logic        snes_latch, snes_clk, valid, busy;
  logic [15:0] buttons;

  int checks = 0, passes = 0, fails = 0;
  int cyc = 0, base = 0;
  logic [15:0] prev = '0;
  logic [15:0] ctrl_raw = 16'hFFFF;
  logic [15:0] sr = 16'hFFFF;

  snes_poller #(.HALF_CYCLES(H), .LATCH_CYCLES(L), .POLL_CYCLES(P)) dut (
    .clock(clock), .reset(reset), .enable(enable), .snes_data(snes_data),
    .snes_latch(snes_latch), .snes_clk(snes_clk), .buttons(buttons),
    .valid(valid), .busy(busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Controller: parallel load while latched, shift out on each rising serial clock.
  always @(posedge snes_latch or posedge snes_clk) begin
    if (snes_latch) sr = ctrl_raw;
    else            sr = {1'b1, sr[15:1]};
  end
  assign snes_data = sr[0];

  task automatic step;
    @(posedge clock); #1;
  endtask

  task automatic chk(input string name, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", name, obs, exp);
    end
  endtask

  task automatic do_reset;
    int vcnt;
    reset = 1'b1;
    #1;
    chk("reset_outputs", {snes_latch, snes_clk, busy, valid, buttons}, {4'b0100, 16'h0000});
    vcnt = 0;
    repeat (4) begin step; vcnt += int'(valid); end
    chk("no_valid_in_reset", 20'(vcnt), 20'd0);
    reset = 1'b0;
    base = cyc;
    prev = '0;
  endtask

  task automatic wait_start;
    int n;
    n = 0;
    while (snes_latch !== 1'b1 && n < P + 10) begin step; n++; end
    chk("latch_seen", 20'(snes_latch), 20'd1);
    chk("start_phase", 20'((cyc - base) % P), 20'd1);
  endtask

  task automatic run_frame(input logic [15:0] raw, input int drop_at);
    logic lat, clk_e, val;
    logic [15:0] btn;
    ctrl_raw = raw;
    wait_start();
    for (int t = 0; t <= FEND; t++) begin
      lat   = (t < L);
      clk_e = (t < L || t >= FEND) ? 1'b1 : (((t - L) / H) % 2 == 1);
      val   = (t == FEND);
      btn   = val ? ~raw : prev;
      chk($sformatf("frame_t%0d", t), {snes_latch, snes_clk, busy, valid, buttons},
          {lat, clk_e, 1'b1, val, btn});
      if (t == drop_at) enable = 1'b0;
      if (t != FEND) step;
    end
    prev = ~raw;
    step;
    chk("post_frame_idle", {snes_latch, snes_clk, busy, valid, buttons}, {4'b0100, prev});
  endtask

  initial begin
    logic [15:0] r;
    int lcnt, vcnt;
    #2;
    do_reset();

    run_frame(16'hFFFF, -1);
    chk("no_controller", 20'(buttons), 20'h00000);
    run_frame(16'hFEF7, -1);
    chk("a_start", 20'(buttons), 20'h00108);
    repeat (2) begin
      run_frame(16'hF000, -1);
      chk("all_twelve", 20'(buttons), 20'h00FFF);
    end
    repeat (4) begin
      r = 16'($urandom);
      run_frame(r, -1);
    end

    // Disable mid-frame: this frame still completes, then the port stays quiet.
    run_frame(16'($urandom), 50);
    lcnt = 0;
    repeat (2*P) begin step; lcnt += int'(snes_latch); end
    chk("no_latch_disabled", 20'(lcnt), 20'd0);
    enable = 1'b1;
    run_frame(16'($urandom), -1);

    // Abort at cycle 100 of a frame.
    ctrl_raw = 16'($urandom);
    wait_start();
    repeat (100) step;
    reset = 1'b1;
    #1;
    chk("abort_async", {snes_latch, snes_clk, busy, valid, buttons}, {4'b0100, 16'h0000});
    vcnt = 0;
    repeat (3) begin step; vcnt += int'(valid); end
    chk("abort_no_valid", 20'(vcnt), 20'd0);
    do_reset();
    run_frame(16'($urandom), -1);

    // Encoder-style source loaded with 8'hA5 (active-high) over three frames.
    repeat (3) begin
      run_frame({8'hFF, ~8'hA5}, -1);
      chk("loopback", 20'(buttons[7:0]), 20'h000A5);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
